fpga_ccff_loader: RTL
=====================

# fpga_ccff_loader

Programming controller for the eFPGA configuration chain. Accepts the bitstream as a word stream with a valid/ready handshake and shifts it serially, LSB first, into the fabric's configuration flip-flop chain. It holds the mapped user design in reset throughout programming, then releases that reset after a fixed number of cycles. It is the block that sequences fabric bring-up ahead of functional checking of a mapped benchmark such as the 8-bit counter.

## Interface
- CHAIN_LEN, 1024: number of configuration bits in the chain (≥1)
- WORD_W, 8: bitstream word width (≥2)
- USER_RST_CYCLES, 2: cycles user_rst stays high after the last shifted bit (≥1)
- CNT_W, $clog2(CHAIN_LEN+1): width of bits_shifted

Ports:
- clk  in  1  single clock for the whole block; all registers update on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)program the fabric
- bs_valid  in  1  bitstream word available
- bs_data  in  WORD_W  bitstream word; bit 0 is shifted first
- bs_ready  out  1  loader accepts a word
- ccff_head  out  1  serial data into the chain
- prog_clk_en  out  1  chain shift enable; the chain advances one bit on every cycle this is high
- user_rst  out  1  active-high reset to the mapped design
- busy  out  1  programming or release sequence in progress
- prog_done  out  1  fabric programmed and user design released
- bits_shifted  out  CNT_W  number of bits shifted since the last start

## Operation
- States: IDLE, LOAD, SHIFT, RELEASE, DONE.
- IDLE: start=1 → LOAD. Clear bits_shifted; busy=1.
- LOAD: bs_ready=1. On bs_valid&bs_ready, latch bs_data into the shift register, clear the per-word bit index, and go to SHIFT. If bs_valid=0, stay in LOAD with prog_clk_en=0.
- SHIFT:
  - Each cycle: prog_clk_en=1, ccff_head=shreg[0], shift shreg right, increment bits_shifted.
  - Leave after WORD_W bits, or earlier when bits_shifted reaches CHAIN_LEN.
  - Next state: LOAD if bits remain; otherwise RELEASE with counter=USER_RST_CYCLES.
- Final partial word: when CHAIN_LEN mod WORD_W ≠ 0, the upper bits of the final word are consumed and discarded. Exactly ceil(CHAIN_LEN/WORD_W) words are accepted.
- RELEASE: prog_clk_en=0, user_rst=1. Decrement the counter each cycle; at 0 go to DONE.
- DONE: user_rst=0, prog_done=1, busy=0. start=1 → LOAD: prog_done=0 and user_rst=1 from the next cycle, bits_shifted cleared.
- start is ignored in LOAD, SHIFT and RELEASE.
- ccff_head=0 whenever prog_clk_en=0.
- bits_shifted saturates at CHAIN_LEN and holds its value in RELEASE and DONE.

## Timing
- Reset values (asynchronous on rst_n=0): state IDLE, bs_ready 0, ccff_head 0, prog_clk_en 0, user_rst 1, busy 0, prog_done 0, bits_shifted 0.
- Reset mid-operation aborts the sequence immediately; no partial state survives, and any remaining words in the source are not consumed.
- All outputs are registered, or are decoded from registered state only. There is no combinational path from inputs to outputs, except bs_ready=(state==LOAD).
- start sampled at edge t → LOAD from cycle t+1.
- Handshake at edge h → first SHIFT cycle at h+1. Each word costs 1 LOAD cycle plus its shift cycles when bs_valid is held high.
- Last SHIFT cycle at s → RELEASE cycles s+1 … s+USER_RST_CYCLES → DONE at s+USER_RST_CYCLES+1, when user_rst falls and prog_done rises together.
- bs_valid low during LOAD inserts idle cycles. No bit is lost or duplicated, and bits_shifted is frozen.
- prog_clk_en is high for exactly CHAIN_LEN cycles per programming sequence.

## Test plan
- Basic programming (CHAIN_LEN=20, WORD_W=8, USER_RST_CYCLES=2), words 0xA5, 0x3C, 0x0F, bs_valid always 1:
  - ccff_head sequence 10100101 00111100 1111; upper nibble of 0x0F discarded.
  - 20 enable cycles; 3 handshakes.
  - prog_done rises 2+1 cycles after the last shift; bits_shifted=20.
- Stall: bs_valid low for 5 cycles before word 2 → prog_clk_en low for those 5 LOAD cycles; head sequence identical to the basic case; completion 5 cycles later.
- start pulses during SHIFT and RELEASE → ignored; no extra handshakes; bits_shifted=20 at end.
- rst_n low during the 3rd shift of word 1 → all outputs at reset values immediately; a new start reprograms from bit 0 with the full 20-bit sequence.
- Reprogram from DONE with start=1 → user_rst=1 and prog_done=0 on the next cycle, bits_shifted=0, bs_ready=1; the new bitstream completes normally.
- CHAIN_LEN=16, WORD_W=8 (exact multiple) → exactly 2 words accepted; the last shift is bit 7 of word 2; no extra LOAD cycle.

Source files
------------

// File: rtl/fpga_ccff_loader.sv
// rtl/fpga_ccff_loader.sv - eFPGA configuration chain loader.
// Shifts a word-stream bitstream LSB first into the CCFF chain, then releases user reset.
module fpga_ccff_loader #(
  parameter int CHAIN_LEN       = 1024,
  parameter int WORD_W          = 8,
  parameter int USER_RST_CYCLES = 2,
  parameter int CNT_W           = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              bs_valid_i,
  input  logic [WORD_W-1:0] bs_data_i,
  output logic              bs_ready_o,
  output logic              ccff_head_o,
  output logic              prog_clk_en_o,
  output logic              user_rst_o,
  output logic              busy_o,
  output logic              prog_done_o,
  output logic [CNT_W-1:0]  bits_shifted_o
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int REL_W = $clog2(USER_RST_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REL_W-1:0] REL_INIT  = REL_W'(USER_RST_CYCLES);
  localparam logic [REL_W-1:0] REL_ONE   = REL_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    RELEASE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic [REL_W-1:0]  rel_q, rel_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
      rel_q   <= rel_d;
    end
  end

  // Outputs decode registered state only; bs_ready is the one direct state decode.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    idx_d          = idx_q;
    bits_d         = bits_q;
    rel_d          = rel_q;
    bs_ready_o     = 1'b0;
    ccff_head_o    = 1'b0;
    prog_clk_en_o  = 1'b0;
    user_rst_o     = 1'b1;
    busy_o         = 1'b0;
    prog_done_o    = 1'b0;
    bits_shifted_o = bits_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          bits_d  = '0;
        end
      end
      LOAD: begin
        busy_o     = 1'b1;
        bs_ready_o = 1'b1;
        if (bs_valid_i) begin
          shreg_d = bs_data_i;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_o        = 1'b1;
        prog_clk_en_o = 1'b1;
        ccff_head_o   = shreg_q[0];
        shreg_d       = shreg_q >> 1;
        idx_d         = idx_q + IDX_ONE;
        if (bits_q != CHAIN_END) begin
          bits_d = bits_q + CNT_ONE;
        end
        // Chain end wins over word end so a partial final word drops its upper bits.
        if (bits_q + CNT_ONE == CHAIN_END) begin
          state_d = RELEASE;
          rel_d   = REL_INIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = LOAD;
        end
      end
      RELEASE: begin
        busy_o = 1'b1;
        rel_d  = rel_q - REL_ONE;
        if (rel_q <= REL_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        user_rst_o  = 1'b0;
        prog_done_o = 1'b1;
        if (start_i) begin
          state_d = LOAD;
          bits_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
